// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline constants and shadow-record types for the hazard/forwarding controller.
// The EX stage imports this package for the same operand-select encodings.
package hazard_fwd_ctrl_pkg;

  localparam int unsigned RegW = 3;
  localparam int unsigned CntW = 16;

  typedef logic [RegW-1:0] reg_idx_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs;
    reg_idx_t rt;
    logic     rs_used;
    logic     rt_used;
    reg_idx_t rd;
    logic     reg_write;
    logic     mem_read;
  } ex_rec_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     reg_write;
    logic     mem_read;
  } stage_rec_t;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] val);
    return (val == {CntW{1'b1}}) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// Operand forward select for one EX source: newest producer (EX/MEM) wins over MEM/WB.
// A load sitting in MEM only holds its address, so it never feeds the EX/MEM path.
module fwd_select
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic       ex_valid_i,
  input  reg_idx_t   src_i,
  input  logic       src_used_i,
  input  stage_rec_t mem_i,
  input  logic       wb_valid_i,
  input  reg_idx_t   wb_rd_i,
  input  logic       wb_reg_write_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (ex_valid_i && src_used_i) begin
      if (mem_i.valid && mem_i.reg_write && !mem_i.mem_read && (mem_i.rd == src_i)) begin
        sel_o = FWD_EXMEM;
      end else if (wb_valid_i && wb_reg_write_i && (wb_rd_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall detection and EX operand forwarding driven by shadow EX/MEM/WB records.
// Outputs are combinational on the current records; only stall_count is registered.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  reg_idx_t        id_rs_i,
  input  reg_idx_t        id_rt_i,
  input  logic            id_rs_used_i,
  input  logic            id_rt_used_i,
  input  reg_idx_t        id_rd_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic            flush_i,
  output logic [1:0]      forward_a_o,
  output logic [1:0]      forward_b_o,
  output logic            stall_o,
  output logic            bubble_o,
  output logic [CntW-1:0] stall_count_o
);

  ex_rec_t         ex_q, ex_d;
  stage_rec_t      mem_q, wb_q;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic            load_use;
  logic            unused_wb;

  // WB mem_read is tracked for completeness; WB forwarding ignores it.
  assign unused_wb = wb_q.mem_read;

  always_comb begin
    load_use = id_valid_i && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
               (((ex_q.rd == id_rs_i) && id_rs_used_i) || ((ex_q.rd == id_rt_i) && id_rt_used_i));
    stall_o  = load_use && !flush_i;
    bubble_o = stall_o || flush_i;
  end

  always_comb begin
    ex_d.valid     = id_valid_i && !bubble_o;
    ex_d.rs        = id_rs_i;
    ex_d.rt        = id_rt_i;
    ex_d.rs_used   = id_rs_used_i;
    ex_d.rt_used   = id_rt_used_i;
    ex_d.rd        = id_rd_i;
    ex_d.reg_write = id_reg_write_i;
    ex_d.mem_read  = id_mem_read_i;
    stall_cnt_d    = stall_o ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                       mem_read: ex_q.mem_read};
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;

  fwd_select u_fwd_a (
    .ex_valid_i     (ex_q.valid),
    .src_i          (ex_q.rs),
    .src_used_i     (ex_q.rs_used),
    .mem_i          (mem_q),
    .wb_valid_i     (wb_q.valid),
    .wb_rd_i        (wb_q.rd),
    .wb_reg_write_i (wb_q.reg_write),
    .sel_o          (forward_a_o)
  );

  fwd_select u_fwd_b (
    .ex_valid_i     (ex_q.valid),
    .src_i          (ex_q.rt),
    .src_used_i     (ex_q.rt_used),
    .mem_i          (mem_q),
    .wb_valid_i     (wb_q.valid),
    .wb_rd_i        (wb_q.rd),
    .wb_reg_write_i (wb_q.reg_write),
    .sel_o          (forward_b_o)
  );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scoreboard bench: the driver pushes hand-computed expectations, the monitor
// pops and compares them each time a sample is announced.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [2:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  forward_a, forward_b;
  logic        stall, bubble;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic        bub;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;

  hazard_fwd_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_rs_used_i   (id_rs_used),
    .id_rt_used_i   (id_rt_used),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .flush_i        (flush),
    .forward_a_o    (forward_a),
    .forward_b_o    (forward_b),
    .stall_o        (stall),
    .bubble_o       (bubble),
    .stall_count_o  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: decoupled from stimulus, consumes one expectation per announced sample.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.name, "forward_a",   {14'd0, forward_a}, {14'd0, e.fa});
        chk(e.name, "forward_b",   {14'd0, forward_b}, {14'd0, e.fb});
        chk(e.name, "stall",       {15'd0, stall},     {15'd0, e.st});
        chk(e.name, "bubble",      {15'd0, bubble},    {15'd0, e.bub});
        chk(e.name, "stall_count", stall_count,        e.cnt);
      end
    end
  end

  task automatic push_exp(input logic [1:0] efa, input logic [1:0] efb, input logic est,
                          input logic eb, input logic [15:0] ec, input string nm);
    exp_t e;
    e.fa = efa; e.fb = efb; e.st = est; e.bub = eb; e.cnt = ec; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic r, input logic fl, input logic v,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic rsu, input logic rtu, input logic [2:0] rd,
                       input logic rw, input logic mr,
                       input logic [1:0] efa, input logic [1:0] efb,
                       input logic est, input logic eb, input logic [15:0] ec,
                       input string nm);
    @(posedge clk);
    #1;
    rst = r; flush = fl; id_valid = v; id_rs = rs; id_rt = rt;
    id_rs_used = rsu; id_rt_used = rtu; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    push_exp(efa, efb, est, eb, ec, nm);
    #1;
    ->sample_ev;
  endtask

  task automatic nop(input logic [1:0] efa, input logic [1:0] efb, input logic [15:0] ec,
                     input string nm);
    issue(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0,
          efa, efb, 1'b0, 1'b0, ec, nm);
  endtask

  initial begin
    // In reset before any edge: bubble follows flush, everything else idle.
    #1;
    flush = 1'b1;
    push_exp(2'b00, 2'b00, 1'b0, 1'b1, 16'd0, "reset_initial");
    #1;
    ->sample_ev;

    // Back-to-back ALU dependency.
    issue(0, 0, 1, 3'd1, 3'd2, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00, 0, 0, 16'd0, "alu_c1");
    issue(0, 0, 1, 3'd3, 3'd5, 1, 1, 3'd4, 1, 0, 2'b00, 2'b00, 0, 0, 16'd0, "alu_c2");
    nop(2'b10, 2'b00, 16'd0, "alu_fwd_exmem");

    // Distance-2 dependency through a NOP.
    issue(0, 0, 1, 3'd1, 3'd2, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00, 0, 0, 16'd0, "d2_c1");
    nop(2'b00, 2'b00, 16'd0, "d2_nop");
    issue(0, 0, 1, 3'd7, 3'd3, 1, 1, 3'd6, 1, 0, 2'b00, 2'b00, 0, 0, 16'd0, "d2_sub");
    nop(2'b00, 2'b01, 16'd0, "d2_fwd_wb");

    // Load-use: one stall, then WB forward.
    issue(0, 0, 1, 3'd1, 3'd0, 1, 0, 3'd2, 1, 1, 2'b00, 2'b00, 0, 0, 16'd0, "lu_ld");
    issue(0, 0, 1, 3'd2, 3'd4, 1, 1, 3'd5, 1, 0, 2'b00, 2'b00, 1, 1, 16'd0, "lu_stall");
    issue(0, 0, 1, 3'd2, 3'd4, 1, 1, 3'd5, 1, 0, 2'b00, 2'b00, 0, 0, 16'd1, "lu_held");
    nop(2'b01, 2'b00, 16'd1, "lu_fwd_wb");

    // Double write to r3: newest wins on both operands.
    issue(0, 0, 1, 3'd1, 3'd2, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00, 0, 0, 16'd1, "dw_c1");
    issue(0, 0, 1, 3'd1, 3'd2, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00, 0, 0, 16'd1, "dw_c2");
    issue(0, 0, 1, 3'd3, 3'd3, 1, 1, 3'd4, 1, 0, 2'b00, 2'b00, 0, 0, 16'd1, "dw_c3");
    nop(2'b10, 2'b10, 16'd1, "dw_newest");

    // Two loads then a consumer of both: exactly one stall.
    issue(0, 0, 1, 3'd1, 3'd0, 1, 0, 3'd2, 1, 1, 2'b00, 2'b00, 0, 0, 16'd1, "ll_ld1");
    issue(0, 0, 1, 3'd1, 3'd0, 1, 0, 3'd3, 1, 1, 2'b00, 2'b00, 0, 0, 16'd1, "ll_ld2");
    issue(0, 0, 1, 3'd2, 3'd3, 1, 1, 3'd6, 1, 0, 2'b00, 2'b00, 1, 1, 16'd1, "ll_stall");
    issue(0, 0, 1, 3'd2, 3'd3, 1, 1, 3'd6, 1, 0, 2'b00, 2'b00, 0, 0, 16'd2, "ll_held");
    nop(2'b00, 2'b01, 16'd2, "ll_fwd");

    // Flush lands in the cycle the load-use stall would assert.
    issue(0, 0, 1, 3'd1, 3'd0, 1, 0, 3'd2, 1, 1, 2'b00, 2'b00, 0, 0, 16'd2, "fl_ld");
    issue(0, 1, 1, 3'd2, 3'd4, 1, 1, 3'd5, 1, 0, 2'b00, 2'b00, 0, 1, 16'd2, "fl_flush");
    issue(0, 0, 1, 3'd1, 3'd1, 1, 1, 3'd7, 1, 0, 2'b00, 2'b00, 0, 0, 16'd2, "fl_killed");
    nop(2'b00, 2'b00, 16'd2, "fl_after");

    // Third stall, then reset between edges.
    issue(0, 0, 1, 3'd1, 3'd0, 1, 0, 3'd2, 1, 1, 2'b00, 2'b00, 0, 0, 16'd2, "rs_ld");
    issue(0, 0, 1, 3'd2, 3'd2, 1, 1, 3'd5, 1, 0, 2'b00, 2'b00, 1, 1, 16'd2, "rs_stall");
    issue(0, 0, 1, 3'd2, 3'd2, 1, 1, 3'd5, 1, 0, 2'b00, 2'b00, 0, 0, 16'd3, "rs_held");
    nop(2'b01, 2'b01, 16'd3, "rs_pre_reset");
    #3;
    rst = 1'b1;
    push_exp(2'b00, 2'b00, 1'b0, 1'b0, 16'd0, "mid_reset");
    #1;
    ->sample_ev;
    issue(1, 1, 1, 3'd2, 3'd2, 1, 1, 3'd1, 1, 0, 2'b00, 2'b00, 0, 1, 16'd0, "reset_flush");
    issue(0, 0, 1, 3'd2, 3'd2, 1, 1, 3'd3, 1, 0, 2'b00, 2'b00, 0, 0, 16'd0, "post_rst_id");
    nop(2'b00, 2'b00, 16'd0, "post_rst_no_fwd");

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: id_valid  in  1  the ID-stage slot holds a real instruction.
REQ-004 SHALL have ports: id_rs, id_rt  in  3 each  source register numbers of the ID instruction.
REQ-005 SHALL have ports: id_rs_used, id_rt_used  in  1 each  the ID instruction actually reads rs / rt.
REQ-006 SHALL have ports: id_rd  in  3  destination register of the ID instruction.
REQ-007 SHALL have ports: id_reg_write, id_mem_read  in  1 each  the ID instruction writes the register file / is a load.
REQ-008 SHALL have ports: flush  in  1  taken branch or jump resolved in EX; the ID instruction is killed.
REQ-009 SHALL have ports: forward_a, forward_b  out  2 each  EX operand select: 2'b10 = EX/MEM result, 2'b01 = MEM/WB result, 2'b00 = register-file value.
REQ-010 SHALL have ports: stall  out  1  hold PC and the IF/ID register this cycle.
REQ-011 SHALL have ports: bubble  out  1  load a NOP into ID/EX at the next edge.
REQ-012 SHALL have ports: stall_count  out  16  count of stall cycles since reset.

Function
REQ-013 SHALL keep shadow stage records for EX, MEM and WB:
- EX record: valid, rs, rt, rs_used, rt_used, rd, reg_write, mem_read.
- MEM and WB records: valid, rd, reg_write, mem_read.
REQ-014 SHALL update the shadow records on each edge as follows:
- MEM record <= EX record.
- WB record <= MEM record.
- EX record <= ID inputs, unless bubble is 1; then EX.valid <= 0.
REQ-015 SHALL assert stall combinationally when all of these hold:
- id_valid = 1, EX.valid = 1, EX.mem_read = 1, EX.reg_write = 1.
- EX.rd equals id_rs with id_rs_used = 1, or EX.rd equals id_rt with id_rt_used = 1.
REQ-016 SHALL drive bubble = stall OR flush.
REQ-017 SHALL force stall to 0 when flush = 1; flush wins over stall.
REQ-018 SHALL drive forward_a = 2'b10 when:
- MEM.valid = 1, MEM.reg_write = 1, MEM.mem_read = 0.
- MEM.rd = EX.rs, EX.rs_used = 1, EX.valid = 1.
REQ-019 SHALL otherwise drive forward_a = 2'b01 when WB.valid = 1, WB.reg_write = 1, WB.rd = EX.rs, EX.rs_used = 1 and EX.valid = 1; otherwise 2'b00.
REQ-020 SHALL compute forward_b identically to forward_a, using EX.rt and EX.rt_used.
REQ-021 SHALL treat register 0 as an ordinary register; there is no hardwired-zero exclusion.
REQ-022 SHALL never select 2'b10 for a load in MEM, because its EX/MEM value is an address; load-use is covered by the stall in REQ-015 plus the WB forward.
REQ-023 SHALL give every combinational output zero latency relative to the current shadow state; there are no registered outputs except stall_count.
REQ-024 SHALL increment stall_count by 1 on each edge where stall = 1, and saturate at 16'hFFFF with no wrap.
REQ-025 SHALL require two consecutive loads feeding a dependent instruction to produce exactly one stall cycle per dependent instruction.

Reset
REQ-026 SHALL, while rst = 1 and independent of clk, clear all shadow valid bits and clear stall_count to 16'h0000.
REQ-027 SHALL therefore, during reset, drive forward_a = forward_b = 2'b00, stall = 0, and bubble = flush.
REQ-028 SHALL resume tracking on the first edge after rst deasserts, with no spurious forwards from stale records.

Structure
REQ-029 SHALL place the forward-select encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_EXMEM = 2'b10 in the shared pipeline constants include; the EX stage uses the same include.
REQ-030 SHALL implement forwarding through one sub-module, fwd_select, which computes the 2-bit select for one operand; it is instantiated twice, for a and b.
REQ-031 SHALL build the shadow records from the existing dff primitives with asynchronous clear.

Verification
REQ-032 SHALL cover back-to-back ALU dependency:
- Stimulus: ADD r3,r1,r2 then ADD r4,r3,r5.
- Required: second instruction in EX sees forward_a = 2'b10, stall = 0.
REQ-033 SHALL cover the distance-2 dependency:
- Stimulus: ADD r3; NOP; SUB r6,r7,r3.
- Required: forward_b = 2'b01 in EX.
REQ-034 SHALL cover load-use:
- Stimulus: LD r2,[r1] then ADD r5,r2,r4.
- Required: stall = 1 and bubble = 1 for exactly 1 cycle, then forward_a = 2'b01, stall_count = 1.
REQ-035 SHALL cover double-write priority:
- Stimulus: ADD r3; ADD r3; ADD r4,r3,r3.
- Required: forward_a = forward_b = 2'b10 (newest value wins).
REQ-036 SHALL cover flush during a load-use hazard:
- Stimulus: flush = 1 in the cycle stall would assert.
- Required: stall = 0, bubble = 1, stall_count unchanged; next cycle EX.valid = 0 and forwards are 2'b00.
REQ-037 SHALL cover reset in mid-operation:
- Stimulus: assert rst between clock edges after 3 stalls.
- Required: stall_count = 0 immediately, no forwards on the first post-reset instruction.
